// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: core write-back vs. debug port,
// plus a clear engine that zeroes r1..r31 one register per cycle.
module regfile_write_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_waddr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_stall,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_waddr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [3:0]        MAX_WAIT_C = 4'(MAX_WAIT);
   localparam logic [ADDR_W-1:0] FIRST_PTR  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] ZERO_ADDR  = '0;
   localparam logic [DATA_W-1:0] ZERO_DATA  = '0;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic              clr_done_q, clr_done_d;
   logic              force_dbg_s;

   // State, clear pointer, debug starvation counter and done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         clr_ptr_q  <= FIRST_PTR;
         wait_cnt_q <= 4'd0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         wait_cnt_q <= wait_cnt_d;
         clr_done_q <= clr_done_d;
      end
   end

   assign force_dbg_s = dbg_req && (wait_cnt_q == MAX_WAIT_C);
   assign clr_done    = clr_done_q;

   // Next-state logic and same-cycle write-port drive; outputs held low while in reset
   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      clr_done_d = 1'b0;
      core_stall = 1'b0;
      dbg_gnt    = 1'b0;
      clr_busy   = 1'b0;
      rf_we      = 1'b0;
      rf_waddr   = ZERO_ADDR;
      rf_wdata   = ZERO_DATA;
      if (reset) begin
         state_d   = ST_IDLE;
         clr_ptr_d = FIRST_PTR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (force_dbg_s) begin
                  dbg_gnt    = 1'b1;
                  core_stall = core_we;
                  rf_waddr   = dbg_waddr;
                  rf_wdata   = dbg_wdata;
                  rf_we      = (dbg_waddr != ZERO_ADDR);
               end else if (core_we) begin
                  rf_waddr = core_waddr;
                  rf_wdata = core_wdata;
                  rf_we    = (core_waddr != ZERO_ADDR);
               end else if (dbg_req) begin
                  dbg_gnt  = 1'b1;
                  rf_waddr = dbg_waddr;
                  rf_wdata = dbg_wdata;
                  rf_we    = (dbg_waddr != ZERO_ADDR);
               end else begin
                  rf_we = 1'b0;
               end
               if (clr_start) begin
                  state_d   = ST_CLEAR;
                  clr_ptr_d = FIRST_PTR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CLEAR: begin
               clr_busy   = 1'b1;
               core_stall = 1'b1;
               rf_we      = 1'b1;
               rf_waddr   = clr_ptr_q;
               rf_wdata   = ZERO_DATA;
               if (clr_ptr_q == LAST_PTR) begin
                  state_d    = ST_IDLE;
                  clr_ptr_d  = FIRST_PTR;
                  clr_done_d = 1'b1;
               end else begin
                  clr_ptr_d = clr_ptr_q + FIRST_PTR;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               clr_ptr_d = FIRST_PTR;
            end
         endcase
      end
   end

   // Starvation counter keeps running through CLEAR so debug is forced first on exit
   always_comb begin
      if (!dbg_req || dbg_gnt) begin
         wait_cnt_d = 4'd0;
      end else if (wait_cnt_q < MAX_WAIT_C) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter: inputs change on the falling edge,
// combinational outputs are sampled 1 time unit later, well before the rising edge.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_we;
   logic [4:0]  core_waddr;
   logic [31:0] core_wdata;
   logic        core_stall;
   logic        dbg_req;
   logic [4:0]  dbg_waddr;
   logic [31:0] dbg_wdata;
   logic        dbg_gnt;
   logic        clr_start;
   logic        clr_busy;
   logic        clr_done;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int err_cnt = 0;
   int chk_cnt = 0;

   regfile_write_arbiter #(
      .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .MAX_WAIT(4)
   ) dut (
      .clk(clk), .reset(reset),
      .core_we(core_we), .core_waddr(core_waddr), .core_wdata(core_wdata),
      .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge, then settle
   task automatic cyc(input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                      input logic dr, input logic [4:0] da, input logic [31:0] dd,
                      input logic cs);
      @(negedge clk);
      core_we = cw; core_waddr = ca; core_wdata = cd;
      dbg_req = dr; dbg_waddr = da; dbg_wdata = dd;
      clr_start = cs;
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_we"},    rf_we,      32'd0);
      check_val({tag, "_waddr"}, rf_waddr,   32'd0);
      check_val({tag, "_wdata"}, rf_wdata,   32'd0);
      check_val({tag, "_stall"}, core_stall, 32'd0);
      check_val({tag, "_gnt"},   dbg_gnt,    32'd0);
      check_val({tag, "_busy"},  clr_busy,   32'd0);
      check_val({tag, "_done"},  clr_done,   32'd0);
   endtask

   initial begin
      reset = 1'b1;
      core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'h55;
      dbg_req = 1'b0; dbg_waddr = 5'd0; dbg_wdata = 32'd0; clr_start = 1'b0;
      #1;
      check_all_zero("reset");

      // Basic core write, zero latency
      @(negedge clk); reset = 1'b0;
      cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
      check_val("core_we",    rf_we,      32'd1);
      check_val("core_waddr", rf_waddr,   32'd5);
      check_val("core_wdata", rf_wdata,   32'hDEADBEEF);
      check_val("core_stall", core_stall, 32'd0);

      // Debug starved by core for 4 cycles, then forced
      for (int c = 0; c < 4; c++) begin
         cyc(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'h1234, 1'b0);
         check_val("starve_gnt",   dbg_gnt,    32'd0);
         check_val("starve_waddr", rf_waddr,   32'd3);
         check_val("starve_stall", core_stall, 32'd0);
      end
      cyc(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'h1234, 1'b0);
      check_val("force_gnt",   dbg_gnt,    32'd1);
      check_val("force_stall", core_stall, 32'd1);
      check_val("force_waddr", rf_waddr,   32'd7);
      check_val("force_wdata", rf_wdata,   32'h1234);
      check_val("force_we",    rf_we,      32'd1);
      cyc(1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0, 32'd0, 1'b0);
      check_val("resume_waddr", rf_waddr,   32'd3);
      check_val("resume_stall", core_stall, 32'd0);
      check_val("resume_gnt",   dbg_gnt,    32'd0);

      // r0 writes are consumed without a register-file write
      cyc(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b0);
      check_val("core_r0_we",    rf_we,      32'd0);
      check_val("core_r0_stall", core_stall, 32'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77, 1'b0);
      check_val("dbg_r0_gnt", dbg_gnt, 32'd1);
      check_val("dbg_r0_we",  rf_we,   32'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h88, 1'b0);
      check_val("dbg_idle_gnt",   dbg_gnt,  32'd1);
      check_val("dbg_idle_waddr", rf_waddr, 32'd12);
      check_val("dbg_idle_we",    rf_we,    32'd1);
      cyc(1'b0, 5'd9, 32'h99, 1'b0, 5'd4, 32'h44, 1'b0);
      check_all_zero("idle");

      // Clear sequence; start cycle still serves the core
      cyc(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1);
      check_val("start_waddr", rf_waddr,   32'd9);
      check_val("start_stall", core_stall, 32'd0);
      check_val("start_busy",  clr_busy,   32'd0);
      for (int k = 1; k <= 31; k++) begin
         cyc(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, (k == 5));
         check_val("clr_waddr", rf_waddr,   32'(k));
         check_val("clr_wdata", rf_wdata,   32'd0);
         check_val("clr_we",    rf_we,      32'd1);
         check_val("clr_stall", core_stall, 32'd1);
         check_val("clr_busy",  clr_busy,   32'd1);
         check_val("clr_done0", clr_done,   32'd0);
      end
      cyc(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0);
      check_val("done_pulse", clr_done,   32'd1);
      check_val("done_busy",  clr_busy,   32'd0);
      check_val("done_waddr", rf_waddr,   32'd9);
      check_val("done_stall", core_stall, 32'd0);
      cyc(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0);
      check_val("done_once", clr_done, 32'd0);

      // Reset during clear aborts with no done pulse
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         cyc(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0);
      end
      check_val("abort_pre_waddr", rf_waddr, 32'd10);
      reset = 1'b1;
      #1;
      check_all_zero("abort");
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 25; k++) begin
         cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
         check_val("abort_done", clr_done, 32'd0);
         check_val("abort_busy", clr_busy, 32'd0);
      end

      // Restarted clear from r1 with debug pending throughout
      cyc(1'b1, 5'd9, 32'h99, 1'b1, 5'd20, 32'hCAFE, 1'b1);
      check_val("rst_start_gnt",   dbg_gnt,  32'd0);
      check_val("rst_start_waddr", rf_waddr, 32'd9);
      for (int k = 1; k <= 31; k++) begin
         cyc(1'b1, 5'd9, 32'h99, 1'b1, 5'd20, 32'hCAFE, 1'b0);
         check_val("clr2_waddr", rf_waddr, 32'(k));
         check_val("clr2_gnt",   dbg_gnt,  32'd0);
      end
      cyc(1'b1, 5'd9, 32'h99, 1'b1, 5'd20, 32'hCAFE, 1'b0);
      check_val("exit_gnt",   dbg_gnt,    32'd1);
      check_val("exit_stall", core_stall, 32'd1);
      check_val("exit_waddr", rf_waddr,   32'd20);
      check_val("exit_wdata", rf_wdata,   32'hCAFE);
      check_val("exit_done",  clr_done,   32'd1);
      cyc(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0);
      check_val("post_waddr", rf_waddr,   32'd9);
      check_val("post_stall", core_stall, 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
